// File: rtl/ws2812_chain_driver.sv
// WS2812 chain driver: streams a NUM_LEDS x 24-bit pixel buffer as WS2812 bit
// frames (GRB, MSB first) followed by a latch/reset low period.
module ws2812_chain_driver #(
    parameter int NUM_LEDS = 8,
    parameter int T0H      = 6,
    parameter int T1H      = 13,
    parameter int TBIT     = 20,
    parameter int TRST     = 1280,
    localparam int AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          start,
    input  logic          loop,
    output logic          busy,
    output logic          done,
    output logic          DOUT
);

    localparam int CMAX = (TBIT > TRST) ? TBIT : TRST;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] C_T0H_M1  = CW'(T0H - 1);
    localparam logic [CW-1:0] C_T1H_M1  = CW'(T1H - 1);
    localparam logic [CW-1:0] C_TBIT_M1 = CW'(TBIT - 1);
    localparam logic [CW-1:0] C_TBIT_M2 = CW'(TBIT - 2);
    localparam logic [CW-1:0] C_TRST_M1 = CW'(TRST - 1);
    localparam logic [AW:0]   ADDR_LIM  = (AW + 1)'(NUM_LEDS);
    localparam logic [AW-1:0] LAST_PIX  = AW'(NUM_LEDS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    bit_idx, bit_n;
    logic [AW-1:0] pix_idx, idx_n;
    logic [23:0]   shreg, sh_n;
    logic [CW-1:0] hi_m1;
    logic          last_pix;
    logic          dout_q;

    logic [23:0]   pixbuf [NUM_LEDS];

    // Buffer is deliberately not reset so pixel contents survive RST.
    always_ff @(posedge CLK) begin
        if (wr_en && ({1'b0, wr_addr} < ADDR_LIM))
            pixbuf[wr_addr] <= wr_data;
    end

    assign hi_m1    = shreg[23] ? C_T1H_M1 : C_T0H_M1;
    assign last_pix = (pix_idx == LAST_PIX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            pix_idx <= '0;
            shreg   <= '0;
            dout_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            pix_idx <= idx_n;
            shreg   <= sh_n;
            dout_q  <= (state == HIGH);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        idx_n   = pix_idx;
        sh_n    = shreg;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (start) begin
                    state_n = LOAD;
                    idx_n   = '0;
                end
            end
            LOAD: begin
                sh_n    = pixbuf[pix_idx];
                bit_n   = 5'd23;
                cnt_n   = '0;
                state_n = HIGH;
            end
            HIGH: begin
                cnt_n = cnt + 1'b1;
                if (cnt >= hi_m1)
                    state_n = LOW;
            end
            LOW: begin
                cnt_n = cnt + 1'b1;
                // Inter-pixel LOAD takes the last cycle of bit 0's period.
                if (bit_idx == 5'd0 && !last_pix) begin
                    if (cnt >= C_TBIT_M2) begin
                        state_n = LOAD;
                        idx_n   = pix_idx + 1'b1;
                    end
                end else if (cnt >= C_TBIT_M1) begin
                    cnt_n = '0;
                    if (bit_idx == 5'd0) begin
                        state_n = LATCH;
                    end else begin
                        state_n = HIGH;
                        bit_n   = bit_idx - 5'd1;
                        sh_n    = {shreg[22:0], 1'b0};
                    end
                end
            end
            LATCH: begin
                cnt_n = cnt + 1'b1;
                if (cnt >= C_TRST_M1) begin
                    done    = 1'b1;
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = loop ? LOAD : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    // Registered DOUT gives the two-cycle start latency with unchanged widths.
    assign DOUT = dout_q;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Scoreboard bench for ws2812_chain_driver: stimulus queues expected bit widths
// and frame timing; a negedge monitor decodes DOUT/done and compares.
module tb_ws2812_chain_driver;

    localparam int NL    = 3;
    localparam int T0H   = 2;
    localparam int T1H   = 4;
    localparam int TBIT  = 6;
    localparam int TRST  = 10;
    localparam int AW    = 2;
    localparam int FRAME = 1 + NL * 24 * TBIT + TRST;

    logic          CLK = 1'b0;
    logic          RST;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          start;
    logic          loop;
    logic          busy;
    logic          done;
    logic          DOUT;

    ws2812_chain_driver #(
        .NUM_LEDS(NL),
        .T0H(T0H),
        .T1H(T1H),
        .TBIT(TBIT),
        .TRST(TRST)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .loop(loop),
        .busy(busy),
        .done(done),
        .DOUT(DOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int len;
        int gap;
    } frame_t;

    int          checks = 0;
    int          errors = 0;
    int          exp_bits[$];
    frame_t      exp_frames[$];
    logic [23:0] model_pix [NL];

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endfunction

    function automatic void push_frame(int gap);
        for (int p = 0; p < NL; p++)
            for (int b = 23; b >= 0; b--)
                exp_bits.push_back(model_pix[p][b] ? T1H : T0H);
        exp_frames.push_back('{len: FRAME, gap: gap});
    endfunction

    // Monitor state
    logic prev_dout = 1'b0;
    logic prev_done = 1'b0;
    logic first_rise = 1'b1;
    int   hi_run = 0;
    int   frame_cyc = 0;
    int   since_rise = 0;
    int   since_done = -1;

    initial begin
        frame_t f;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_dout  = 1'b0;
                prev_done  = 1'b0;
                first_rise = 1'b1;
                hi_run     = 0;
                frame_cyc  = 0;
                since_rise = 0;
                since_done = -1;
            end else begin
                if (busy) frame_cyc++;
                if (since_done >= 0) since_done++;
                since_rise++;
                if (DOUT) hi_run++;
                if (DOUT && !prev_dout) begin
                    if (first_rise) check("start_to_rise", frame_cyc - 1, 2);
                    else            check("bit_period", since_rise, TBIT);
                    first_rise = 1'b0;
                    since_rise = 0;
                end
                if (!DOUT && prev_dout) begin
                    if (exp_bits.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bit actual width %0d required none", hi_run);
                    end else begin
                        check("bit_high", hi_run, exp_bits.pop_front());
                    end
                    hi_run = 0;
                end
                if (done) begin
                    check("done_width", int'(prev_done), 0);
                    if (exp_frames.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual 1 required 0");
                    end else begin
                        f = exp_frames.pop_front();
                        check("frame_busy", frame_cyc, f.len);
                        if (f.gap > 0) check("done_gap", since_done, f.gap);
                    end
                    since_done = 0;
                    frame_cyc  = 0;
                    first_rise = 1'b1;
                end
                prev_dout = DOUT;
                prev_done = done;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_pix(int a, logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a < NL) model_pix[a] = d;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(int budget, string tag);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s actual no done required done within %0d cycles", tag, budget);
        end
    endtask

    task automatic wait_rises(int n, int budget);
        int   seen = 0;
        logic p    = DOUT;
        for (int i = 0; i < budget && seen < n; i++) begin
            @(negedge CLK);
            if (DOUT && !p) seen++;
            p = DOUT;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL timeout_rises actual %0d required %0d", seen, n);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; loop = 1'b0;
        repeat (3) tick();
        check("reset_busy", int'(busy), 0);
        check("reset_dout", int'(DOUT), 0);
        check("reset_done", int'(done), 0);
        RST = 1'b0;
        tick();

        // Basic frame
        write_pix(0, 24'hAA0000);
        write_pix(1, 24'h000001);
        write_pix(2, 24'h5A5A5A);
        push_frame(0);
        pulse_start();
        wait_done(600, "basic");
        @(negedge CLK);
        check("busy_after_done", int'(busy), 0);
        tick();

        // Start pulsed during LATCH is ignored
        push_frame(0);
        pulse_start();
        repeat (437) tick();
        pulse_start();
        wait_done(600, "latch_start");
        repeat (30) tick();
        check("busy_after_latch_start", int'(busy), 0);

        // Start held high: one IDLE cycle between frames
        push_frame(0);
        push_frame(FRAME + 1);
        start = 1'b1;
        wait_done(600, "held1");
        tick();
        tick();
        start = 1'b0;
        wait_done(600, "held2");
        @(negedge CLK);
        check("busy_after_held", int'(busy), 0);
        tick();

        // Loop mode: back-to-back frames, busy never drops
        loop = 1'b1;
        push_frame(0);
        push_frame(FRAME);
        pulse_start();
        wait_done(600, "loop1");
        tick();
        loop = 1'b0;
        wait_done(600, "loop2");
        @(negedge CLK);
        check("busy_after_loop", int'(busy), 0);
        tick();

        // Writes during a frame; out-of-range write ignored
        model_pix[1] = 24'hFFFFFF;
        push_frame(0);
        pulse_start();
        repeat (20) tick();
        write_pix(1, 24'hFFFFFF);
        write_pix(0, 24'h123456);
        write_pix(3, 24'hDEADBE);
        wait_done(600, "wr_busy");
        tick();
        push_frame(0);
        pulse_start();
        wait_done(600, "wr_next");
        tick();

        // Reset mid-frame, then a full frame from index 0
        push_frame(0);
        pulse_start();
        wait_rises(14, 300);
        check("dout_before_rst", int'(DOUT), 1);
        RST = 1'b1;
        #1;
        check("rst_dout", int'(DOUT), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        exp_bits.delete();
        exp_frames.delete();
        repeat (2) tick();
        RST = 1'b0;
        tick();
        push_frame(0);
        pulse_start();
        wait_done(600, "after_rst");
        repeat (5) tick();

        check("bits_left", exp_bits.size(), 0);
        check("frames_left", exp_frames.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
